// File: rtl/apb_protocol_monitor.sv
// Passive APB4 protocol monitor. Classifies every sampled bus cycle as IDLE, SETUP or ACCESS.
// Raises sticky violation flags with a first-error code. Keeps transfer and wait-state statistics.
// state_o shows the phase of the most recently sampled cycle.
module apb_protocol_monitor #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [2:0]            PPROT,
  input  logic [NUM_SLAVES-1:0] PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [STRB_WIDTH-1:0] PSTRB,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PSLVERR,
  input  logic                  clr_err,
  output logic [2:0]            state_o,
  output logic [7:0]            err_flags,
  output logic                  err_valid,
  output logic [2:0]            err_first,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [CNT_WIDTH-1:0]  xfer_count,
  output logic [CNT_WIDTH-1:0]  wait_max
);

  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);
  localparam logic [2:0] StIdle   = 3'b001;
  localparam logic [2:0] StSetup  = 3'b010;
  localparam logic [2:0] StAccess = 3'b100;
  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  logic [2:0]            st_q, st_d;
  logic                  acc_open_q, acc_open_d;  // last ACCESS sample was a wait state
  logic [WaitW-1:0]      wait_q, wait_d;
  logic [ADDR_WIDTH-1:0] lat_addr_q;
  logic [2:0]            lat_prot_q;
  logic [NUM_SLAVES-1:0] lat_sel_q;
  logic                  lat_write_q;
  logic [DATA_WIDTH-1:0] lat_wdata_q;
  logic [STRB_WIDTH-1:0] lat_strb_q;
  logic [7:0]            flags_q, flags_d;
  logic                  valid_q, valid_d;
  logic [2:0]            first_q, first_d;
  logic [CNT_WIDTH-1:0]  ecnt_q, ecnt_d;
  logic [CNT_WIDTH-1:0]  xfer_q, xfer_d;
  logic [CNT_WIDTH-1:0]  wmax_q, wmax_d;

  logic                  sel_any, sel_multi, expect_new, latch, acc_entry, acc_cmp;
  logic                  in_acc, complete, mismatch;
  logic [WaitW-1:0]      wait_base;
  logic [CNT_WIDTH-1:0]  wait_sat;
  logic [7:0]            det;
  logic                  unused_prdata;

  assign sel_any   = |PSEL;
  assign sel_multi = (PSEL & (PSEL - NUM_SLAVES'(1))) != '0;
  // A completed ACCESS behaves like IDLE for the next sample.
  assign expect_new = (st_q == StIdle) || ((st_q == StAccess) && !acc_open_q);
  assign unused_prdata = ^PRDATA;

  assign mismatch = (PADDR != lat_addr_q) || (PPROT != lat_prot_q) || (PSEL != lat_sel_q) ||
                    (PWRITE != lat_write_q) || (PSTRB != lat_strb_q) ||
                    (lat_write_q && (PWDATA != lat_wdata_q));

  // Phase classification of the current sample and protocol checks
  always_comb begin
    st_d      = st_q;
    latch     = 1'b0;
    acc_entry = 1'b0;
    acc_cmp   = 1'b0;
    det       = '0;
    if (expect_new) begin
      if (sel_any && !PENABLE) begin
        st_d  = StSetup;
        latch = 1'b1;
      end else if (sel_any) begin
        st_d      = StAccess;
        latch     = 1'b1;
        acc_entry = 1'b1;
        det[1]    = 1'b1;
      end else begin
        st_d = StIdle;
      end
    end else if (st_q == StSetup) begin
      if (sel_any && PENABLE) begin
        st_d      = StAccess;
        acc_entry = 1'b1;
        acc_cmp   = 1'b1;
      end else if (sel_any) begin
        st_d   = StSetup;
        latch  = 1'b1;
        det[2] = 1'b1;
      end else begin
        st_d   = StIdle;
        det[7] = 1'b1;
      end
    end else begin
      if (sel_any && PENABLE) begin
        st_d    = StAccess;
        acc_cmp = 1'b1;
      end else if (sel_any) begin
        // PENABLE dropped mid-wait: the open transfer is abandoned, treat as a fresh SETUP.
        st_d   = StSetup;
        latch  = 1'b1;
        det[7] = 1'b1;
      end else begin
        st_d   = StIdle;
        det[7] = 1'b1;
      end
    end

    in_acc     = (st_d == StAccess);
    complete   = in_acc && PREADY;
    acc_open_d = in_acc && !PREADY;
    wait_base  = acc_entry ? '0 : wait_q;

    wait_d = wait_q;
    if (in_acc) begin
      if (PREADY) begin
        wait_d = '0;
      end else if (wait_base == WaitW'(TIMEOUT)) begin
        wait_d = wait_base;
      end else begin
        wait_d = wait_base + WaitW'(1);
      end
    end

    det[0] = sel_multi;
    det[3] = acc_cmp && mismatch;
    det[4] = in_acc && !PREADY && (wait_base == WaitW'(TIMEOUT - 1));
    det[5] = PSLVERR && !(sel_any && PENABLE && PREADY);
    det[6] = ((st_d == StSetup) || in_acc) && !PWRITE && (PSTRB != '0);
  end

  // Error bookkeeping and statistics; a same-cycle clear is applied before new detections
  always_comb begin
    logic [7:0]           flags_base, new_bits;
    logic                 valid_base;
    logic [2:0]           first_base, first_idx;
    logic [CNT_WIDTH-1:0] ecnt_base;
    flags_base = clr_err ? '0 : flags_q;
    valid_base = clr_err ? 1'b0 : valid_q;
    first_base = clr_err ? '0 : first_q;
    ecnt_base  = clr_err ? '0 : ecnt_q;
    new_bits   = det & ~flags_base;

    first_idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (det[i]) first_idx = 3'(i);
    end

    flags_d = flags_base | det;
    valid_d = valid_base || (det != '0);
    first_d = (!valid_base && (det != '0)) ? first_idx : first_base;
    ecnt_d  = ecnt_base;
    if ((new_bits != '0) && (ecnt_base != CntMax)) ecnt_d = ecnt_base + CNT_WIDTH'(1);

    if (64'(wait_base) > 64'(CntMax)) wait_sat = CntMax;
    else                              wait_sat = CNT_WIDTH'(wait_base);

    xfer_d = xfer_q;
    wmax_d = wmax_q;
    if (complete) begin
      if (xfer_q != CntMax) xfer_d = xfer_q + CNT_WIDTH'(1);
      if (wait_sat > wmax_q) wmax_d = wait_sat;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      st_q        <= StIdle;
      acc_open_q  <= 1'b0;
      wait_q      <= '0;
      lat_addr_q  <= '0;
      lat_prot_q  <= '0;
      lat_sel_q   <= '0;
      lat_write_q <= 1'b0;
      lat_wdata_q <= '0;
      lat_strb_q  <= '0;
      flags_q     <= '0;
      valid_q     <= 1'b0;
      first_q     <= '0;
      ecnt_q      <= '0;
      xfer_q      <= '0;
      wmax_q      <= '0;
    end else begin
      st_q       <= st_d;
      acc_open_q <= acc_open_d;
      wait_q     <= wait_d;
      if (latch) begin
        lat_addr_q  <= PADDR;
        lat_prot_q  <= PPROT;
        lat_sel_q   <= PSEL;
        lat_write_q <= PWRITE;
        lat_wdata_q <= PWDATA;
        lat_strb_q  <= PSTRB;
      end
      flags_q <= flags_d;
      valid_q <= valid_d;
      first_q <= first_d;
      ecnt_q  <= ecnt_d;
      xfer_q  <= xfer_d;
      wmax_q  <= wmax_d;
    end
  end

  assign state_o    = st_q;
  assign err_flags  = flags_q;
  assign err_valid  = valid_q;
  assign err_first  = first_q;
  assign err_count  = ecnt_q;
  assign xfer_count = xfer_q;
  assign wait_max   = wmax_q;

endmodule

// File: tb/tb_apb_protocol_monitor.sv
// Directed, table-driven bench for apb_protocol_monitor with hand-computed expectations.
module tb_apb_protocol_monitor;

  logic        clk = 1'b0;
  logic        PRESET = 1'b1;
  logic [31:0] PADDR = '0;
  logic [2:0]  PPROT = '0;
  logic [3:0]  PSEL = '0;
  logic        PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PWDATA = '0, PRDATA = '0;
  logic [3:0]  PSTRB = '0;
  logic        PREADY = 1'b0, PSLVERR = 1'b0, clr_err = 1'b0;
  logic [2:0]  state_o;
  logic [7:0]  err_flags;
  logic        err_valid;
  logic [2:0]  err_first;
  logic [7:0]  err_count, xfer_count, wait_max;

  apb_protocol_monitor #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_SLAVES(4), .TIMEOUT(16), .CNT_WIDTH(8)
  ) dut (
    .PCLK(clk), .PRESET(PRESET), .PADDR(PADDR), .PPROT(PPROT), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY),
    .PRDATA(PRDATA), .PSLVERR(PSLVERR), .clr_err(clr_err), .state_o(state_o),
    .err_flags(err_flags), .err_valid(err_valid), .err_first(err_first),
    .err_count(err_count), .xfer_count(xfer_count), .wait_max(wait_max)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst; logic clr; logic [3:0] sel; logic en; logic wr;
    logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb; logic rdy; logic slverr;
    logic [2:0] e_st; logic [7:0] e_flags; logic [2:0] e_first; logic [7:0] e_ecnt;
    logic [7:0] e_xfer; logic [7:0] e_wmax;
  } vec_t;

  vec_t tbl [30];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one bus sample, let it clock in, then check every output.
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    PRESET = v.rst; clr_err = v.clr; PSEL = v.sel; PENABLE = v.en; PWRITE = v.wr;
    PADDR = v.addr; PWDATA = v.wdata; PSTRB = v.strb; PREADY = v.rdy; PSLVERR = v.slverr;
    @(posedge clk);
    #1;
    chk($sformatf("%s state", tag), 32'(state_o), 32'(v.e_st));
    chk($sformatf("%s flags", tag), 32'(err_flags), 32'(v.e_flags));
    chk($sformatf("%s valid", tag), 32'(err_valid), 32'(v.e_flags != 8'h00));
    chk($sformatf("%s first", tag), 32'(err_first), 32'(v.e_first));
    chk($sformatf("%s ecnt", tag), 32'(err_count), 32'(v.e_ecnt));
    chk($sformatf("%s xfer", tag), 32'(xfer_count), 32'(v.e_xfer));
    chk($sformatf("%s wmax", tag), 32'(wait_max), 32'(v.e_wmax));
  endtask

  initial begin
    vec_t v;
    // rst clr sel en wr addr wdata strb rdy slverr | state flags first ecnt xfer wmax
    tbl[0]  = '{1'b1,1'b0,4'h0,1'b0,1'b0,32'h00,32'h0,4'h0,1'b0,1'b0, 3'b001,8'h00,3'd0,8'd0,8'd0,8'd0};
    tbl[1]  = '{1'b0,1'b0,4'h0,1'b0,1'b0,32'h00,32'h0,4'h0,1'b0,1'b0, 3'b001,8'h00,3'd0,8'd0,8'd0,8'd0};
    // clean write, no waits
    tbl[2]  = '{1'b0,1'b0,4'h1,1'b0,1'b1,32'h10,32'hA5A5A5A5,4'hF,1'b0,1'b0,
                3'b010,8'h00,3'd0,8'd0,8'd0,8'd0};
    tbl[3]  = '{1'b0,1'b0,4'h1,1'b1,1'b1,32'h10,32'hA5A5A5A5,4'hF,1'b1,1'b0,
                3'b100,8'h00,3'd0,8'd0,8'd1,8'd0};
    tbl[4]  = '{1'b0,1'b0,4'h0,1'b0,1'b0,32'h00,32'h0,4'h0,1'b0,1'b0, 3'b001,8'h00,3'd0,8'd0,8'd1,8'd0};
    // read, 3 waits, PSTRB=0
    tbl[5]  = '{1'b0,1'b0,4'h1,1'b0,1'b0,32'h20,32'h0,4'h0,1'b0,1'b0, 3'b010,8'h00,3'd0,8'd0,8'd1,8'd0};
    tbl[6]  = '{1'b0,1'b0,4'h1,1'b1,1'b0,32'h20,32'h0,4'h0,1'b0,1'b0, 3'b100,8'h00,3'd0,8'd0,8'd1,8'd0};
    tbl[7]  = tbl[6];
    tbl[8]  = tbl[6];
    tbl[9]  = '{1'b0,1'b0,4'h1,1'b1,1'b0,32'h20,32'h0,4'h0,1'b1,1'b0, 3'b100,8'h00,3'd0,8'd0,8'd2,8'd3};
    tbl[10] = '{1'b0,1'b0,4'h0,1'b0,1'b0,32'h00,32'h0,4'h0,1'b0,1'b0, 3'b001,8'h00,3'd0,8'd0,8'd2,8'd3};
    // read, 3 waits, PSTRB=3 -> bit6
    tbl[11] = '{1'b0,1'b0,4'h1,1'b0,1'b0,32'h20,32'h0,4'h3,1'b0,1'b0, 3'b010,8'h40,3'd6,8'd1,8'd2,8'd3};
    tbl[12] = '{1'b0,1'b0,4'h1,1'b1,1'b0,32'h20,32'h0,4'h3,1'b0,1'b0, 3'b100,8'h40,3'd6,8'd1,8'd2,8'd3};
    tbl[13] = tbl[12];
    tbl[14] = tbl[12];
    tbl[15] = '{1'b0,1'b0,4'h1,1'b1,1'b0,32'h20,32'h0,4'h3,1'b1,1'b0, 3'b100,8'h40,3'd6,8'd1,8'd3,8'd3};
    tbl[16] = '{1'b0,1'b0,4'h0,1'b0,1'b0,32'h00,32'h0,4'h0,1'b0,1'b0, 3'b001,8'h40,3'd6,8'd1,8'd3,8'd3};
    tbl[17] = '{1'b0,1'b1,4'h0,1'b0,1'b0,32'h00,32'h0,4'h0,1'b0,1'b0, 3'b001,8'h00,3'd0,8'd0,8'd3,8'd3};
    // PSLVERR in SETUP, then PADDR moves 0x10->0x14 in ACCESS
    tbl[18] = '{1'b0,1'b0,4'h1,1'b0,1'b1,32'h10,32'h1234,4'hF,1'b0,1'b1,
                3'b010,8'h20,3'd5,8'd1,8'd3,8'd3};
    tbl[19] = '{1'b0,1'b0,4'h1,1'b1,1'b1,32'h14,32'h1234,4'hF,1'b0,1'b0,
                3'b100,8'h28,3'd5,8'd2,8'd3,8'd3};
    tbl[20] = '{1'b0,1'b0,4'h1,1'b1,1'b1,32'h14,32'h1234,4'hF,1'b1,1'b0,
                3'b100,8'h28,3'd5,8'd2,8'd4,8'd3};
    tbl[21] = '{1'b0,1'b0,4'h0,1'b0,1'b0,32'h00,32'h0,4'h0,1'b0,1'b0, 3'b001,8'h28,3'd5,8'd2,8'd4,8'd3};
    tbl[22] = '{1'b0,1'b1,4'h0,1'b0,1'b0,32'h00,32'h0,4'h0,1'b0,1'b0, 3'b001,8'h00,3'd0,8'd0,8'd4,8'd3};
    // multi-select in SETUP, then PSEL dropped mid-ACCESS
    tbl[23] = '{1'b0,1'b0,4'h3,1'b0,1'b1,32'h30,32'h0,4'hF,1'b0,1'b0, 3'b010,8'h01,3'd0,8'd1,8'd4,8'd3};
    tbl[24] = '{1'b0,1'b0,4'h3,1'b1,1'b1,32'h30,32'h0,4'hF,1'b0,1'b0, 3'b100,8'h01,3'd0,8'd1,8'd4,8'd3};
    tbl[25] = '{1'b0,1'b0,4'h0,1'b0,1'b0,32'h00,32'h0,4'h0,1'b0,1'b0, 3'b001,8'h81,3'd0,8'd2,8'd4,8'd3};
    // clr_err together with a PENABLE-without-SETUP violation, then reset mid-ACCESS
    tbl[26] = '{1'b0,1'b1,4'h1,1'b1,1'b1,32'h40,32'h0,4'hF,1'b0,1'b0, 3'b100,8'h02,3'd1,8'd1,8'd4,8'd3};
    tbl[27] = '{1'b0,1'b0,4'h1,1'b1,1'b1,32'h40,32'h0,4'hF,1'b0,1'b0, 3'b100,8'h02,3'd1,8'd1,8'd4,8'd3};
    tbl[28] = '{1'b1,1'b0,4'h1,1'b1,1'b1,32'h40,32'h0,4'hF,1'b0,1'b0, 3'b001,8'h00,3'd0,8'd0,8'd0,8'd0};
    tbl[29] = '{1'b0,1'b0,4'h0,1'b0,1'b0,32'h00,32'h0,4'h0,1'b0,1'b0, 3'b001,8'h00,3'd0,8'd0,8'd0,8'd0};

    for (int i = 0; i < 30; i++) apply(tbl[i], $sformatf("v%0d", i));

    // Timeout: 20 wait cycles, bit4 appears exactly at the 16th and is counted once.
    v = '{1'b0,1'b0,4'h1,1'b0,1'b1,32'h50,32'h0,4'hF,1'b0,1'b0, 3'b010,8'h00,3'd0,8'd0,8'd0,8'd0};
    apply(v, "to_setup");
    for (int k = 1; k <= 20; k++) begin
      v = '{1'b0,1'b0,4'h1,1'b1,1'b1,32'h50,32'h0,4'hF,1'b0,1'b0, 3'b100,
            (k >= 16) ? 8'h10 : 8'h00, (k >= 16) ? 3'd4 : 3'd0, (k >= 16) ? 8'd1 : 8'd0,
            8'd0, 8'd0};
      apply(v, $sformatf("to_wait%0d", k));
    end
    v = '{1'b0,1'b0,4'h1,1'b1,1'b1,32'h50,32'h0,4'hF,1'b1,1'b0, 3'b100,8'h10,3'd4,8'd1,8'd1,8'd16};
    apply(v, "to_done");
    // Back-to-back: new SETUP right after completion, then a zero-wait ACCESS.
    v = '{1'b0,1'b0,4'h2,1'b0,1'b1,32'h60,32'h0,4'hF,1'b0,1'b0, 3'b010,8'h10,3'd4,8'd1,8'd1,8'd16};
    apply(v, "b2b_setup");
    v = '{1'b0,1'b0,4'h2,1'b1,1'b1,32'h60,32'h0,4'hF,1'b1,1'b0, 3'b100,8'h10,3'd4,8'd1,8'd2,8'd16};
    apply(v, "b2b_done");
    v = '{1'b0,1'b0,4'h0,1'b0,1'b0,32'h00,32'h0,4'h0,1'b0,1'b0, 3'b001,8'h10,3'd4,8'd1,8'd2,8'd16};
    apply(v, "b2b_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
